// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_pkg
// Description : Shared bus widths, memory op codes, access sizes and FSM
//               state encoding for the MEM pipeline stage.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_pkg;

    typedef logic [31:0] RegBus;
    typedef logic [4:0]  RegAddrBus;
    typedef logic [7:0]  AluOpBus;

    localparam RegBus ZeroWord  = 32'h0000_0000;
    localparam logic  RstEnable = 1'b1;

    // Memory op codes (shared with the decode stage)
    localparam AluOpBus c_op_lb  = 8'b1110_0000;
    localparam AluOpBus c_op_lh  = 8'b1110_0001;
    localparam AluOpBus c_op_lw  = 8'b1110_0011;
    localparam AluOpBus c_op_lbu = 8'b1110_0100;
    localparam AluOpBus c_op_lhu = 8'b1110_0101;
    localparam AluOpBus c_op_sb  = 8'b1110_1000;
    localparam AluOpBus c_op_sh  = 8'b1110_1001;
    localparam AluOpBus c_op_sw  = 8'b1110_1011;

    // Access size encoding used by the lane formatter
    localparam logic [1:0] c_size_byte = 2'd0;
    localparam logic [1:0] c_size_half = 2'd1;
    localparam logic [1:0] c_size_word = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_e;

endpackage
`default_nettype wire

// File: rtl/mem_lane_fmt.sv
`default_nettype none
// ============================================================================
// Module      : mem_lane_fmt
// Description : Combinational byte-lane formatter. Decodes the memory op,
//               produces byte enables, replicated store data, the extended
//               load value and the misalignment flag (little-endian).
// Ports       : op          - ALU op code
//               addr_lo     - effective address bits [1:0]
//               store_data  - register value to store
//               load_data   - raw bus read data
//               is_mem      - op is a load or store
//               is_load     - op is a load
//               misaligned  - address not aligned to the access size
//               sel         - byte enables, bit n covers bits 8n+7:8n
//               store_wdata - store data replicated across all lanes
//               load_ext    - selected lane, sign/zero extended
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_fmt
    import mem_access_pkg::*;
(
    input  AluOpBus    op,
    input  logic [1:0] addr_lo,
    input  RegBus      store_data,
    input  RegBus      load_data,
    output logic       is_mem,
    output logic       is_load,
    output logic       misaligned,
    output logic [3:0] sel,
    output RegBus      store_wdata,
    output RegBus      load_ext
);

    logic [1:0]  w_size;
    logic        w_signed;
    logic [15:0] w_lane;

    // Shift the addressed lane down to bit 0; a halfword only ever starts
    // at lane 0 or 2, so 16 bits are enough for every load size below word.
    assign w_lane = 16'(load_data >> {addr_lo, 3'b000});

    always_comb begin
        is_mem   = 1'b1;
        is_load  = 1'b0;
        w_signed = 1'b0;
        w_size   = c_size_word;
        case (op)
            c_op_lb:  begin is_load = 1'b1; w_signed = 1'b1; w_size = c_size_byte; end
            c_op_lbu: begin is_load = 1'b1;                  w_size = c_size_byte; end
            c_op_lh:  begin is_load = 1'b1; w_signed = 1'b1; w_size = c_size_half; end
            c_op_lhu: begin is_load = 1'b1;                  w_size = c_size_half; end
            c_op_lw:  begin is_load = 1'b1;                  w_size = c_size_word; end
            c_op_sb:  w_size = c_size_byte;
            c_op_sh:  w_size = c_size_half;
            c_op_sw:  w_size = c_size_word;
            default:  is_mem = 1'b0;
        endcase
    end

    always_comb begin
        sel         = 4'b0000;
        store_wdata = ZeroWord;
        load_ext    = ZeroWord;
        misaligned  = 1'b0;
        if (is_mem) begin
            case (w_size)
                c_size_byte: begin
                    sel         = 4'b0001 << addr_lo;
                    store_wdata = {4{store_data[7:0]}};
                    load_ext    = {{24{w_signed & w_lane[7]}}, w_lane[7:0]};
                end
                c_size_half: begin
                    sel         = addr_lo[1] ? 4'b1100 : 4'b0011;
                    store_wdata = {2{store_data[15:0]}};
                    load_ext    = {{16{w_signed & w_lane[15]}}, w_lane};
                    misaligned  = addr_lo[0];
                end
                default: begin
                    sel         = 4'b1111;
                    store_wdata = store_data;
                    load_ext    = load_data;
                    misaligned  = |addr_lo;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module      : mem_access
// Description : MEM pipeline stage. Passes ALU results through for
//               non-memory ops; performs loads/stores on a single-outstanding
//               req/ack bus, stalling upstream stages for the access.
// Ports       : clk, rst (sync, active-high)
//               flush_i, aluOp_i, wd_i, wreg_i, wdata_i, memAddr_i,
//               storeData_i                - from EX/MEM register
//               wd_o, wreg_o, wdata_o      - to MEM/WB register
//               stall_req_o                - freeze upstream pipeline
//               align_err_o                - misaligned access (comb)
//               bus_err_o                  - one-cycle timeout pulse
//               bus_req_o .. bus_wdata_o   - registered data-bus request
//               bus_rdata_i, bus_ack_i     - data-bus response
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush_i,
    input  AluOpBus    aluOp_i,
    input  RegAddrBus  wd_i,
    input  logic       wreg_i,
    input  RegBus      wdata_i,
    input  RegBus      memAddr_i,
    input  RegBus      storeData_i,
    output RegAddrBus  wd_o,
    output logic       wreg_o,
    output RegBus      wdata_o,
    output logic       stall_req_o,
    output logic       align_err_o,
    output logic       bus_err_o,
    output logic       bus_req_o,
    output logic       bus_we_o,
    output RegBus      bus_addr_o,
    output logic [3:0] bus_sel_o,
    output RegBus      bus_wdata_o,
    input  RegBus      bus_rdata_i,
    input  logic       bus_ack_i
);

    localparam int                CNT_W      = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  c_cnt_last = CNT_W'(TIMEOUT - 1);

    mem_state_e       r_state;
    mem_state_e       w_next;
    logic             r_req;
    logic             r_we;
    RegBus            r_addr;
    logic [3:0]       r_sel;
    RegBus            r_wdata;
    RegBus            r_result;
    logic [CNT_W-1:0] r_cnt;
    logic             r_timed_out;
    logic             r_flushed;
    logic             r_bus_err;

    logic             w_is_mem;
    logic             w_is_load;
    logic             w_misaligned;
    logic [3:0]       w_sel;
    RegBus            w_store_wdata;
    RegBus            w_load_ext;
    logic             w_start;
    logic             w_cnt_expired;

    mem_lane_fmt u_lane_fmt (
        .op          (aluOp_i),
        .addr_lo     (memAddr_i[1:0]),
        .store_data  (storeData_i),
        .load_data   (bus_rdata_i),
        .is_mem      (w_is_mem),
        .is_load     (w_is_load),
        .misaligned  (w_misaligned),
        .sel         (w_sel),
        .store_wdata (w_store_wdata),
        .load_ext    (w_load_ext)
    );

    assign w_start       = (r_state == IDLE) && w_is_mem && !w_misaligned && !flush_i;
    assign w_cnt_expired = (r_cnt == c_cnt_last);

    // Next state and MEM/WB-facing outputs
    always_comb begin
        w_next      = r_state;
        wd_o        = wd_i;
        wreg_o      = 1'b0;
        wdata_o     = wdata_i;
        stall_req_o = 1'b0;
        align_err_o = w_is_mem && w_misaligned;
        if (rst == RstEnable) begin
            w_next      = IDLE;
            wd_o        = 5'd0;
            wdata_o     = ZeroWord;
            align_err_o = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_is_mem) begin
                        wreg_o = wreg_i && !flush_i;
                    end else if (w_start) begin
                        stall_req_o = 1'b1;
                        w_next      = BUSY;
                    end
                end
                BUSY: begin
                    stall_req_o = 1'b1;
                    // ack and expiry in the same cycle: ack wins in the
                    // register process; both lead to DONE here.
                    if (bus_ack_i || w_cnt_expired) begin
                        w_next = DONE;
                    end
                end
                DONE: begin
                    w_next  = IDLE;
                    wdata_o = r_result;
                    if (w_is_load && !r_timed_out && !r_flushed && !flush_i) begin
                        wreg_o = wreg_i;
                    end
                end
                default: w_next = IDLE;
            endcase
        end
    end

    // State, bus request and result registers
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_state     <= IDLE;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= ZeroWord;
            r_sel       <= 4'b0000;
            r_wdata     <= ZeroWord;
            r_result    <= ZeroWord;
            r_cnt       <= '0;
            r_timed_out <= 1'b0;
            r_flushed   <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_bus_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_req       <= 1'b1;
                        r_we        <= !w_is_load;
                        r_addr      <= {memAddr_i[31:2], 2'b00};
                        r_sel       <= w_sel;
                        r_wdata     <= w_store_wdata;
                        r_cnt       <= '0;
                        r_result    <= ZeroWord;
                        r_timed_out <= 1'b0;
                        r_flushed   <= 1'b0;
                    end
                end
                BUSY: begin
                    r_cnt <= r_cnt + 1'b1;
                    // A flush cannot cancel an in-flight bus cycle; remember
                    // it so the DONE result is dropped instead.
                    if (flush_i) begin
                        r_flushed <= 1'b1;
                    end
                    if (bus_ack_i) begin
                        r_req    <= 1'b0;
                        r_result <= w_is_load ? w_load_ext : ZeroWord;
                    end else if (w_cnt_expired) begin
                        r_req       <= 1'b0;
                        r_timed_out <= 1'b1;
                        r_bus_err   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus_req_o   = r_req;
    assign bus_we_o    = r_we;
    assign bus_addr_o  = r_addr;
    assign bus_sel_o   = r_sel;
    assign bus_wdata_o = r_wdata;
    assign bus_err_o   = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access
// Description : Self-checking bench for mem_access: directed vector table,
//               hand-written reset/flush sequences and randomized
//               transactions against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access;
    import mem_access_pkg::*;

    localparam logic [7:0] OP_OR  = 8'h25;
    localparam logic [7:0] OP_NOP = 8'h00;

    typedef struct {
        int          stall;
        int          req;
        logic [3:0]  sel;
        logic [31:0] baddr;
        logic        we;
        logic [31:0] bwdata;
        logic        wreg;
        logic [31:0] wdata;
        logic [4:0]  wd;
        logic        align;
        int          err;
        logic        stable;
    } exp_t;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          ack_d;
        int          flush_at;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic [7:0]  aluOp_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic [31:0] memAddr_i;
    logic [31:0] storeData_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stall_req_o;
    logic        align_err_o;
    logic        bus_err_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;

    always #5 clk = ~clk;

    mem_access #(.TIMEOUT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .aluOp_i     (aluOp_i),
        .wd_i        (wd_i),
        .wreg_i      (wreg_i),
        .wdata_i     (wdata_i),
        .memAddr_i   (memAddr_i),
        .storeData_i (storeData_i),
        .wd_o        (wd_o),
        .wreg_o      (wreg_o),
        .wdata_o     (wdata_o),
        .stall_req_o (stall_req_o),
        .align_err_o (align_err_o),
        .bus_err_o   (bus_err_o),
        .bus_req_o   (bus_req_o),
        .bus_we_o    (bus_we_o),
        .bus_addr_o  (bus_addr_o),
        .bus_sel_o   (bus_sel_o),
        .bus_wdata_o (bus_wdata_o),
        .bus_rdata_i (bus_rdata_i),
        .bus_ack_i   (bus_ack_i)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [7:0] op);
        case (op)
            c_op_lb, c_op_lbu, c_op_sb: return 1;
            c_op_lh, c_op_lhu, c_op_sh: return 2;
            c_op_lw, c_op_sw:           return 4;
            default:                    return 0;
        endcase
    endfunction

    function automatic bit is_ld(input logic [7:0] op);
        return op == c_op_lb || op == c_op_lbu || op == c_op_lh ||
               op == c_op_lhu || op == c_op_lw;
    endfunction

    function automatic exp_t model(input vec_t v);
        exp_t        e;
        int          sz, busy, ofs;
        bit          timed, flushed;
        logic [31:0] mask, val;
        e        = '{default: 0};
        e.stable = 1'b1;
        e.wd     = v.wd;
        sz       = size_of(v.op);
        if (sz == 0) begin
            e.wreg  = v.wreg;
            e.wdata = v.wdata;
            return e;
        end
        if (v.addr % sz != 0) begin
            e.align = 1'b1;
            return e;
        end
        ofs     = int'(v.addr % 4);
        timed   = !(v.ack_d >= 0 && v.ack_d <= 15);
        busy    = timed ? 16 : v.ack_d + 1;
        flushed = (v.flush_at >= 0 && v.flush_at <= busy);
        e.stall = busy + 1;
        e.req   = busy;
        e.err   = timed ? 1 : 0;
        e.baddr = v.addr - (v.addr % 4);
        e.sel   = 4'(((1 << sz) - 1) << ofs);
        e.we    = !is_ld(v.op);
        if (e.we) begin
            if (sz == 1)      e.bwdata = (v.sdata % 256) * 32'h0101_0101;
            else if (sz == 2) e.bwdata = (v.sdata % 65536) * 32'h0001_0001;
            else              e.bwdata = v.sdata;
        end else begin
            mask = (sz == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * sz)) - 1;
            val  = (v.rdata >> (8 * ofs)) & mask;
            if ((v.op == c_op_lb || v.op == c_op_lh) && val > (mask >> 1))
                val = val | ~mask;
            e.wdata = val;
            e.wreg  = (!timed && !flushed) ? v.wreg : 1'b0;
        end
        return e;
    endfunction

    // ---------------- transaction driver ----------------
    task automatic set_idle();
        aluOp_i = OP_NOP; wreg_i = 1'b0; wd_i = 5'd0; wdata_i = 32'h0;
        memAddr_i = 32'h0; storeData_i = 32'h0; flush_i = 1'b0; bus_ack_i = 1'b0;
    endtask

    task automatic capture_result(inout exp_t o);
        o.wd = wd_o; o.wreg = wreg_o; o.wdata = wdata_o;
    endtask

    task automatic run_txn(input vec_t v, output exp_t o);
        int k;
        bit done;
        o = '{default: 0};
        o.stable = 1'b1;
        @(posedge clk); #1;
        aluOp_i = v.op; memAddr_i = v.addr; storeData_i = v.sdata; bus_rdata_i = v.rdata;
        wd_i = v.wd; wreg_i = v.wreg; wdata_i = v.wdata; flush_i = 1'b0; bus_ack_i = 1'b0;
        @(negedge clk);
        o.align = align_err_o; o.err += int'(bus_err_o); o.req += int'(bus_req_o);
        if (stall_req_o) begin
            o.stall = 1;
            k = 0; done = 0;
            while (!done && k < 40) begin
                @(posedge clk); #1;
                bus_ack_i = (k == v.ack_d);
                flush_i   = (k == v.flush_at);
                @(negedge clk);
                o.err += int'(bus_err_o); o.req += int'(bus_req_o);
                if (stall_req_o) begin
                    o.stall++;
                    if (o.stall == 2) begin
                        o.sel = bus_sel_o; o.baddr = bus_addr_o; o.we = bus_we_o; o.bwdata = bus_wdata_o;
                    end else if (bus_sel_o !== o.sel || bus_addr_o !== o.baddr ||
                                 bus_we_o !== o.we || bus_wdata_o !== o.bwdata) begin
                        o.stable = 1'b0;
                    end
                end else begin
                    done = 1;
                    capture_result(o);
                end
                k++;
            end
            if (!done) chk("txn_bound", 32'(done), 32'd1);
        end else begin
            capture_result(o);
        end
        @(posedge clk); #1;
        set_idle();
        @(negedge clk);
        o.err += int'(bus_err_o); o.req += int'(bus_req_o);
    endtask

    task automatic compare(input string tag, input exp_t e, input exp_t o);
        chk({tag, ".stall"}, 32'(o.stall), 32'(e.stall));
        chk({tag, ".req"},   32'(o.req),   32'(e.req));
        chk({tag, ".align"}, 32'(o.align), 32'(e.align));
        chk({tag, ".err"},   32'(o.err),   32'(e.err));
        chk({tag, ".wd"},    32'(o.wd),    32'(e.wd));
        chk({tag, ".wreg"},  32'(o.wreg),  32'(e.wreg));
        if (e.wreg) chk({tag, ".wdata"}, o.wdata, e.wdata);
        if (e.req > 0) begin
            chk({tag, ".sel"},    32'(o.sel),    32'(e.sel));
            chk({tag, ".baddr"},  o.baddr,       e.baddr);
            chk({tag, ".we"},     32'(o.we),     32'(e.we));
            chk({tag, ".stable"}, 32'(o.stable), 32'(e.stable));
            if (e.we) chk({tag, ".bwdata"}, o.bwdata, e.bwdata);
        end
    endtask

    vec_t tbl[16];
    vec_t v;
    exp_t o, e;
    logic [7:0] mem_ops[8];

    initial begin
        // op, addr, sdata, rdata, ack_d, flush_at, wd, wreg, wdata,
        // exp {stall, req, sel, baddr, we, bwdata, wreg, wdata, wd, align, err, stable}
        tbl[0]  = '{OP_OR,   32'h0,   32'h0, 32'h0, -1, -1, 5'd3, 1'b1, 32'h0000F0F0,
                    '{0, 0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0000F0F0, 5'd3, 1'b0, 0, 1'b1}};
        tbl[1]  = '{c_op_lb, 32'h103, 32'h0, 32'h80FF1234, 0, -1, 5'd5, 1'b1, 32'hDEAD,
                    '{2, 1, 4'b1000, 32'h100, 1'b0, 32'h0, 1'b1, 32'hFFFFFF80, 5'd5, 1'b0, 0, 1'b1}};
        tbl[2]  = '{c_op_lhu, 32'h202, 32'h0, 32'hBEEF0000, 2, -1, 5'd6, 1'b1, 32'h0,
                    '{4, 3, 4'b1100, 32'h200, 1'b0, 32'h0, 1'b1, 32'h0000BEEF, 5'd6, 1'b0, 0, 1'b1}};
        tbl[3]  = '{c_op_sh, 32'h202, 32'h1234ABCD, 32'h0, 1, -1, 5'd7, 1'b1, 32'h0,
                    '{3, 2, 4'b1100, 32'h200, 1'b1, 32'hABCDABCD, 1'b0, 32'h0, 5'd7, 1'b0, 0, 1'b1}};
        tbl[4]  = '{c_op_lw, 32'h301, 32'h0, 32'h0, 0, -1, 5'd8, 1'b1, 32'h0,
                    '{0, 0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 5'd8, 1'b1, 0, 1'b1}};
        tbl[5]  = '{c_op_lw, 32'h400, 32'h0, 32'h11223344, -1, -1, 5'd9, 1'b1, 32'h0,
                    '{17, 16, 4'b1111, 32'h400, 1'b0, 32'h0, 1'b0, 32'h0, 5'd9, 1'b0, 1, 1'b1}};
        tbl[6]  = '{c_op_lw, 32'h404, 32'h0, 32'h11223344, 15, -1, 5'd10, 1'b1, 32'h0,
                    '{17, 16, 4'b1111, 32'h404, 1'b0, 32'h0, 1'b1, 32'h11223344, 5'd10, 1'b0, 0, 1'b1}};
        tbl[7]  = '{c_op_sb, 32'h501, 32'h777777A5, 32'h0, 0, -1, 5'd11, 1'b1, 32'h0,
                    '{2, 1, 4'b0010, 32'h500, 1'b1, 32'hA5A5A5A5, 1'b0, 32'h0, 5'd11, 1'b0, 0, 1'b1}};
        tbl[8]  = '{c_op_lh, 32'h602, 32'h0, 32'h80010000, 0, -1, 5'd12, 1'b1, 32'h0,
                    '{2, 1, 4'b1100, 32'h600, 1'b0, 32'h0, 1'b1, 32'hFFFF8001, 5'd12, 1'b0, 0, 1'b1}};
        tbl[9]  = '{c_op_lbu, 32'h700, 32'h0, 32'h123456FE, 1, -1, 5'd13, 1'b1, 32'h0,
                    '{3, 2, 4'b0001, 32'h700, 1'b0, 32'h0, 1'b1, 32'h000000FE, 5'd13, 1'b0, 0, 1'b1}};
        tbl[10] = '{c_op_sw, 32'h800, 32'hCAFEF00D, 32'h0, 0, -1, 5'd14, 1'b1, 32'h0,
                    '{2, 1, 4'b1111, 32'h800, 1'b1, 32'hCAFEF00D, 1'b0, 32'h0, 5'd14, 1'b0, 0, 1'b1}};
        tbl[11] = '{c_op_lh, 32'h601, 32'h0, 32'h0, 0, -1, 5'd15, 1'b1, 32'h0,
                    '{0, 0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 5'd15, 1'b1, 0, 1'b1}};
        tbl[12] = '{c_op_sw, 32'h900, 32'h5, 32'h0, 3, 1, 5'd16, 1'b1, 32'h0,
                    '{5, 4, 4'b1111, 32'h900, 1'b1, 32'h5, 1'b0, 32'h0, 5'd16, 1'b0, 0, 1'b1}};
        tbl[13] = '{c_op_lw, 32'hA00, 32'h0, 32'h99, 2, 0, 5'd17, 1'b1, 32'h0,
                    '{4, 3, 4'b1111, 32'hA00, 1'b0, 32'h0, 1'b0, 32'h0, 5'd17, 1'b0, 0, 1'b1}};
        tbl[14] = '{c_op_lw, 32'hB00, 32'h0, 32'h1, 16, -1, 5'd18, 1'b1, 32'h0,
                    '{17, 16, 4'b1111, 32'hB00, 1'b0, 32'h0, 1'b0, 32'h0, 5'd18, 1'b0, 1, 1'b1}};
        tbl[15] = '{c_op_lb, 32'hC02, 32'h0, 32'h007F0000, 0, -1, 5'd19, 1'b1, 32'h0,
                    '{2, 1, 4'b0100, 32'hC00, 1'b0, 32'h0, 1'b1, 32'h0000007F, 5'd19, 1'b0, 0, 1'b1}};
        mem_ops = '{c_op_lb, c_op_lbu, c_op_lh, c_op_lhu, c_op_lw, c_op_sb, c_op_sh, c_op_sw};

        // Reset: drive an op that would otherwise produce outputs
        rst = 1'b1; set_idle(); bus_rdata_i = 32'h0;
        aluOp_i = c_op_lw; memAddr_i = 32'h301; wreg_i = 1'b1; wd_i = 5'd9; wdata_i = 32'h1234;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.wd",     32'(wd_o),        32'd0);
        chk("rst.wreg",   32'(wreg_o),      32'd0);
        chk("rst.wdata",  wdata_o,          32'd0);
        chk("rst.stall",  32'(stall_req_o), 32'd0);
        chk("rst.align",  32'(align_err_o), 32'd0);
        chk("rst.req",    32'(bus_req_o),   32'd0);
        chk("rst.we",     32'(bus_we_o),    32'd0);
        chk("rst.addr",   bus_addr_o,       32'd0);
        chk("rst.sel",    32'(bus_sel_o),   32'd0);
        chk("rst.bwdata", bus_wdata_o,      32'd0);
        chk("rst.err",    32'(bus_err_o),   32'd0);
        @(posedge clk); #1;
        rst = 1'b0; set_idle();

        for (int i = 0; i < 16; i++) begin
            run_txn(tbl[i], o);
            compare($sformatf("vec%0d", i), tbl[i].e, o);
        end

        // Reset in the middle of a BUSY load
        @(posedge clk); #1;
        aluOp_i = c_op_lw; memAddr_i = 32'hD00; wreg_i = 1'b1; wd_i = 5'd20;
        @(negedge clk);
        chk("rstbusy.stall_start", 32'(stall_req_o), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstbusy.req_busy", 32'(bus_req_o), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rstbusy.wd",    32'(wd_o),        32'd0);
        chk("rstbusy.wreg",  32'(wreg_o),      32'd0);
        chk("rstbusy.wdata", wdata_o,          32'd0);
        chk("rstbusy.stall", 32'(stall_req_o), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        aluOp_i = OP_OR; wreg_i = 1'b1; wd_i = 5'd4; wdata_i = 32'h55;
        @(negedge clk);
        chk("rstbusy.req_after",   32'(bus_req_o),   32'd0);
        chk("rstbusy.sel_after",   32'(bus_sel_o),   32'd0);
        chk("rstbusy.addr_after",  bus_addr_o,       32'd0);
        chk("rstbusy.stall_after", 32'(stall_req_o), 32'd0);
        chk("rstbusy.wreg_after",  32'(wreg_o),      32'd1);
        chk("rstbusy.wdata_after", wdata_o,          32'h55);

        // Flush of an aligned load in IDLE: nothing starts
        @(posedge clk); #1;
        aluOp_i = c_op_lw; memAddr_i = 32'hE00; wreg_i = 1'b1; wd_i = 5'd21; flush_i = 1'b1;
        @(negedge clk);
        chk("flushidle.stall", 32'(stall_req_o), 32'd0);
        chk("flushidle.wreg",  32'(wreg_o),      32'd0);
        @(posedge clk); #1;
        set_idle();
        @(negedge clk);
        chk("flushidle.req", 32'(bus_req_o), 32'd0);

        // Randomized transactions against the reference model
        for (int n = 0; n < 80; n++) begin
            int pick, r;
            pick = $urandom_range(0, 9);
            if (pick < 8) begin
                v.op = mem_ops[pick];
            end else begin
                v.op = 8'($urandom);
                while (size_of(v.op) != 0) v.op = v.op + 8'd1;
            end
            v.addr = $urandom;
            if ($urandom_range(0, 2) != 0) v.addr[1:0] = 2'b00;
            v.sdata = $urandom;
            v.rdata = $urandom;
            r = $urandom_range(0, 9);
            if (r < 6)       v.ack_d = $urandom_range(0, 4);
            else if (r == 6) v.ack_d = 15;
            else if (r == 7) v.ack_d = 16;
            else if (r == 8) v.ack_d = -1;
            else             v.ack_d = 14;
            v.flush_at = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 3) : -1;
            v.wd    = 5'($urandom);
            v.wreg  = ($urandom_range(0, 4) != 0);
            v.wdata = $urandom;
            e = model(v);
            v.e = e;
            run_txn(v, o);
            compare($sformatf("rnd%0d", n), e, o);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM pipeline stage directly downstream of the execute stage, behind the EX/MEM pipeline register.
- Passes ALU results through for non-memory ops.
- Performs loads/stores on a single-outstanding req/ack data bus: byte-lane select, store data replication, load sign/zero extension, misalignment check.
- Stalls the pipeline for the duration of each bus access; feeds the MEM/WB register.

Parameters:
- TIMEOUT, 16, bus cycles without ack before the access is abandoned with bus_err_o (counter width = clog2(TIMEOUT+1)).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- flush_i  in  1  discard current instruction
- aluOp_i  in  8  op code from EX/MEM register
- wd_i  in  5  destination register address
- wreg_i  in  1  register write enable
- wdata_i  in  32  ALU result, non-memory ops
- memAddr_i  in  32  effective address
- storeData_i  in  32  rt value for stores
- wd_o  out  5  to MEM/WB
- wreg_o  out  1  to MEM/WB
- wdata_o  out  32  to MEM/WB
- stall_req_o  out  1  freeze PC/IF/ID/EX/EX-MEM
- align_err_o  out  1  misaligned access, combinational
- bus_err_o  out  1  one-cycle pulse on timeout
- bus_req_o  out  1  registered bus request
- bus_we_o  out  1  1 = store
- bus_addr_o  out  32  word address; low 2 bits are 0
- bus_sel_o  out  4  byte enables; bit n = bits 8n+7:8n
- bus_wdata_o  out  32  store data
- bus_rdata_i  in  32  load data, valid with ack
- bus_ack_i  in  1  access complete

Behaviour:
- Reset (rst=1 at edge): state IDLE; bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o, timeout counter, result register, bus_err_o all 0.
- While rst=1, combinational outputs are wd_o=0, wreg_o=0, wdata_o=0, stall_req_o=0, align_err_o=0.
- rst mid-access aborts immediately; bus_req_o is 0 after the edge.
- Memory ops: LB, LBU, LH, LHU, LW, SB, SH, SW. Op codes are shared constants. All other ops are non-memory.
- Byte order is little-endian: addr[1:0]=0 selects bits 7:0.
  - SB: sel = 1<<a[1:0]; wdata = byte replicated x4.
  - SH: sel = a[1] ? 1100 : 0011; wdata = half replicated x2.
  - SW: sel = 1111.
  - Loads use the same sel.
  - LB/LH sign-extend the selected lane; LBU/LHU zero-extend it.
- Alignment: halfword needs a[0]=0; word needs a[1:0]=0.
- Misaligned op: align_err_o=1, no bus access, wreg_o=0, stall_req_o=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Non-memory op: wd_o=wd_i, wreg_o=wreg_i, wdata_o=wdata_i, stall 0.
  - Aligned memory op with flush_i=0: stall_req_o=1 and wreg_o=0. Next edge: bus_* registered, bus_req_o=1, counter cleared, state BUSY.
- BUSY:
  - stall_req_o=1, wreg_o=0; bus_* held stable; counter increments each cycle.
  - bus_ack_i=1: capture the extended load data (0 for stores) into the result register, drop bus_req_o, go DONE.
  - Counter reaches TIMEOUT-1 with no ack: drop bus_req_o, set error flag, go DONE, pulse bus_err_o for one cycle.
  - A late ack after timeout is ignored.
- DONE:
  - stall_req_o=0; wd_o=wd_i.
  - Loads: wreg_o=wreg_i and wdata_o=result, unless timed out or flushed.
  - Stores: wreg_o=0.
  - Next edge: IDLE. Upstream has advanced by then.
- Load latency: 3 cycles minimum (present, BUSY+ack, DONE).
- flush_i:
  - In IDLE or DONE: this cycle's wreg_o=0, no access starts, next state IDLE.
  - In BUSY: latched; the access completes (bus protocol is never violated) and the DONE result is discarded.
- ack in the same cycle as timeout expiry: ack wins.

Decomposition:
- Shared defines package: RegBus(31:0), RegAddrBus(4:0), AluOpBus(7:0), ZeroWord, RstEnable, the eight memory op codes, and the FSM state encodings.
- One sub-module: mem_lane_fmt. It is combinational and produces sel, replicated store data, and load extension from (op, addr[1:0], data).

Test Plan:
- OR result: wdata_i=0x0000F0F0, wreg_i=1, wd_i=3 -> same cycle wdata_o=0x0000F0F0, wreg_o=1, stall 0, no bus_req.
- LB addr 0x103, rdata 0x80FF1234, ack on first BUSY cycle -> sel 1000, bus_addr 0x100, DONE wdata_o=0xFFFFFF80, stall high for 2 cycles.
- LHU addr 0x202 with rdata 0xBEEF0000 -> wdata_o=0x0000BEEF. SH addr 0x202 with storeData 0x1234ABCD -> sel 1100, wdata 0xABCDABCD, we=1, wreg_o=0.
- LW addr 0x301 -> align_err_o=1, bus_req stays 0, wreg_o=0, stall 0.
- LW with ack never asserted, TIMEOUT=16 -> bus_req high exactly 16 cycles, one-cycle bus_err_o, wreg_o=0 in DONE. Ack in the 16th cycle instead -> normal completion, no error.
- flush_i pulse during BUSY SW -> req held until ack, DONE wreg_o=0. rst during BUSY -> bus_req_o=0 next cycle, all outputs 0.
